// File: rtl/pipe_latch_pkg.sv
// pipe_latch_pkg: shared state encoding, control-bit indices and default parameters
package pipe_latch_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  localparam int CTRL_MEM_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_BRANCH    = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 3;
  localparam int DEF_SKID   = 1;
  localparam int DEF_CNT_W  = 16;
endpackage

// File: rtl/pipe_latch_slot.sv
// pipe_latch_slot: load-enabled {ctrl,data} register with synchronous reset
module pipe_latch_slot
  import pipe_latch_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [DATA_W-1:0] data_q
);
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else if (load) begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/pipe_latch.sv
// pipe_latch: pipeline stage latch with optional skid slot, flush and saturating stall counter
module pipe_latch
  import pipe_latch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int SKID   = DEF_SKID,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);
  state_t st, st_nx;
  logic in_x, out_x, main_ld, skid_ld;
  logic [CTRL_W-1:0] main_c, skid_c, main_cd;
  logic [DATA_W-1:0] skid_d, main_dd;

  assign in_x      = in_valid && in_ready;
  assign out_x     = out_valid && out_ready;
  assign out_valid = st != EMPTY;
  assign out_ctrl  = out_valid ? main_c : '0;

  always_comb begin
    st_nx = st;
    if (flush) st_nx = EMPTY;
    else if (st == EMPTY) st_nx = in_x ? ONE : EMPTY;
    else if (st == ONE) st_nx = (in_x && !out_x && SKID != 0) ? TWO : (out_x && !in_x) ? EMPTY : ONE;
    else st_nx = out_x ? ONE : TWO;
  end

  assign main_ld = (st == EMPTY && in_x) || (st == ONE && in_x && out_x) || (st == TWO && out_x);
  assign skid_ld = st == ONE && in_x && !out_x;
  assign main_cd = st == TWO ? skid_c : in_ctrl;
  assign main_dd = st == TWO ? skid_d : in_data;

  always_ff @(posedge clk) begin
    st <= reset ? EMPTY : st_nx;
    if (reset || cnt_clr) stall_cnt <= '0;
    else if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  pipe_latch_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk(clk), .reset(reset), .load(main_ld),
    .ctrl_d(main_cd), .data_d(main_dd), .ctrl_q(main_c), .data_q(out_data)
  );

  if (SKID != 0) begin : g_skid
    logic rdy_q;
    // ready is precomputed from the next state; reset is masked so it reads 0 while held in reset
    always_ff @(posedge clk) rdy_q <= reset ? 1'b1 : st_nx != TWO;
    assign in_ready = !reset && rdy_q;
    pipe_latch_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk(clk), .reset(reset), .load(skid_ld),
      .ctrl_d(in_ctrl), .data_d(in_data), .ctrl_q(skid_c), .data_q(skid_d)
    );
  end else begin : g_latch
    assign in_ready = !reset && (!out_valid || out_ready);
    assign skid_c   = '0;
    assign skid_d   = '0;
  end
endmodule

// File: doc/pipe_latch.md
PIPE_LATCH -- requirements
Module: pipe_latch

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits.
REQ-002 Parameter CTRL_W, default 3, control-field width; bit0 mem_write, bit1 mem_read, bit2 branch.
REQ-003 Parameter SKID, default 1. 1 gives a two-entry skid stage with registered in_ready; 0 gives a single-entry latch with combinational in_ready.
REQ-004 Parameter CNT_W, default 16, stall-counter width.
REQ-005 The design SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 in_valid  in  1  upstream entry offered.
REQ-009 in_ready  out  1  stage accepts the entry this cycle.
REQ-010 in_ctrl  in  CTRL_W  upstream control bits.
REQ-011 in_data  in  DATA_W  upstream payload.
REQ-012 flush  in  1  discard all held and incoming entries.
REQ-013 out_valid  out  1  entry presented downstream.
REQ-014 out_ready  in  1  downstream accepts.
REQ-015 out_ctrl  out  CTRL_W  held control bits, gated by out_valid.
REQ-016 out_data  out  DATA_W  held payload.
REQ-017 cnt_clr  in  1  clear the stall counter.
REQ-018 stall_cnt  out  CNT_W  saturating count of stalled cycles.

Function
REQ-019 A transfer SHALL occur on the rising edge where valid and ready are both high on the same side.
REQ-020 The stage SHALL hold state EMPTY, ONE (main slot full) or TWO (main and skid slots full). TWO is reachable only when SKID=1.
REQ-021 EMPTY: in_valid moves to ONE, otherwise the stage stays in EMPTY.
REQ-022 ONE: state transitions SHALL follow the input and output transfers:
- input and output transfer -> ONE, with the main slot replaced by the new entry;
- input transfer only -> TWO (new entry into skid) when SKID=1;
- output transfer only -> EMPTY;
- otherwise ONE, holding the entry.
REQ-023 TWO: output transfer -> ONE with the skid entry moved into main; otherwise TWO.
REQ-024 SKID=1: in_ready SHALL be a register, high exactly when next state is not TWO.
REQ-025 SKID=0: in_ready = !out_valid | out_ready, combinational.
REQ-026 Order SHALL be preserved and no entry SHALL be duplicated or dropped, except by flush.
REQ-027 Latency: an entry accepted at edge N SHALL appear on out_* in the cycle after edge N when the stage was EMPTY.
REQ-028 out_valid SHALL be high exactly in states ONE and TWO.
REQ-029 out_ctrl SHALL be 0 whenever out_valid is 0 (bubble); out_data is don't-care then but SHALL NOT change while out_valid & !out_ready.
REQ-030 flush SHALL force next state EMPTY from any state and SHALL take priority over all transfers.
REQ-031 An input handshake coinciding with flush SHALL be discarded. An output handshake coinciding with flush SHALL count as delivered.
REQ-032 stall_cnt SHALL increment on each cycle with out_valid & !out_ready and saturate at all-ones.
REQ-033 cnt_clr SHALL set stall_cnt to 0 on the next edge; cnt_clr SHALL override a simultaneous increment.
REQ-034 flush SHALL NOT affect stall_cnt.

Reset
REQ-035 On reset the stage SHALL enter EMPTY with out_valid=0, out_ctrl=0, out_data=0 and stall_cnt=0.
REQ-036 in_ready SHALL be 0 while reset is high and 1 in the first cycle after reset releases.
REQ-037 Reset mid-operation SHALL discard all held entries; reset SHALL override flush and cnt_clr.

Structure
REQ-038 A shared package pipe_latch_pkg SHALL hold the state encoding (EMPTY/ONE/TWO), the control-bit index constants (CTRL_MEM_WRITE=0, CTRL_MEM_READ=1, CTRL_BRANCH=2) and the default parameter values.
REQ-039 One sub-module, pipe_latch_slot, SHALL implement a single load-enabled {ctrl,data} register with synchronous reset; it is instantiated for main, and for skid when SKID=1.

Verification
REQ-040 Reset, then in_ctrl=3'b111, in_data=32'hA5A5_0001, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_ctrl=3'b111, out_data=32'hA5A5_0001; the cycle after, out_valid=0 and out_ctrl=0.
REQ-041 SKID=1, out_ready=0, stream 0x10, 0x11, 0x12 -> 0x10 and 0x11 are accepted, in_ready drops after the second accept, 0x12 is held upstream, and stall_cnt increments every cycle; release out_ready -> 0x10, 0x11, 0x12 emerge in order without gaps.
REQ-042 SKID=0, back-to-back stream 0x1..0x8 with out_ready toggling 1,0 each cycle -> all 8 are delivered in order and in_ready equals !out_valid|out_ready every cycle.
REQ-043 In state TWO assert flush with in_valid=1 and out_ready=0 -> next cycle out_valid=0 and out_ctrl=0, nothing from before the flush appears later, and stall_cnt is unchanged by the flush.
REQ-044 CNT_W=4, hold stall for 20 cycles -> stall_cnt saturates at 4'hF; assert cnt_clr together with continued stall -> stall_cnt=0 on the next edge, then 1.
REQ-045 Assert reset while in TWO -> the next cycle shows out_valid=0, stall_cnt=0 and in_ready=0; the cycle after release shows in_ready=1.
